and16_rr_sched: RTL and testbench

- Round-robin scheduler that time-shares one And16 datapath instance between NREQ requesters.
- Each requester presents two 16-bit operands through a valid/ready handshake.
- The block grants one requester, registers the bitwise AND result, and returns it on a shared response channel tagged with the requester index.
- Sits between the register-file/ALU clients and the single And16 gate array, so the logic array is not duplicated per client.

---
 rtl/and16_rr_sched_pkg.sv | 17 +
 rtl/and16_rr_sched_if.sv | 30 +++
 rtl/and16.sv | 13 +
 rtl/rr_pick.sv | 32 +++
 rtl/and16_rr_sched.sv | 120 ++++++++++++
 tb/tb_and16_rr_sched.sv | 197 +++++++++++++++++++
 6 files changed

// File: rtl/and16_rr_sched_pkg.sv
// Shared types and constants for the round-robin And16 scheduler.
// Holds the state encodings, the data width and a pointer helper.
package and16_rr_sched_pkg;

   localparam int W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic int nxt_ptr(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/and16_rr_sched_if.sv
// Request/response bundle between the clients and the shared And16 block.
// master = client side, slave = scheduler side.
interface and16_rr_sched_if
   import and16_rr_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [W*NREQ-1:0] req_a;
   logic [W*NREQ-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [W-1:0]      rsp_data;
   logic [IDW-1:0]    rsp_id;
   logic              busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

endinterface

// File: rtl/and16.sv
// Plain 16-bit bitwise AND gate array.
// Shared by all requesters through the scheduler.
module and16
   import and16_rr_sched_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = a & b;

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first valid bit at or after ptr, wrapping.
// Gives a one-hot grant plus its encoded index.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   int j;

   // scan from ptr upward, first hit wins
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!any && valid[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/and16_rr_sched.sv
// Round-robin scheduler sharing one And16 among NREQ requesters.
// Define AND16_RR_SCHED_PERF_EN for perf_count/stall_count outputs.
module and16_rr_sched
   import and16_rr_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   and16_rr_sched_if.slave  bus
`ifdef AND16_RR_SCHED_PERF_EN
   ,
   output logic [W-1:0]     perf_count,
   output logic [W-1:0]     stall_count
`endif
);

   state_t         state;
   state_t         nstate;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] pick_idx;
   logic [NREQ-1:0] pick_gnt;
   logic           pick_any;
   logic           hs;
   logic [IDW-1:0] lid;
   logic [W-1:0]   la;
   logic [W-1:0]   lb;
   logic [W-1:0]   and_y;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .valid (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (pick_gnt),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   and16 u_and (
      .a (la),
      .b (lb),
      .y (and_y)
   );

   assign hs = (state == ST_IDLE) && pick_any && rst_n;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nstate;
   end

   // next-state logic
   always_comb begin
      nstate = state;
      unique case (state)
         ST_IDLE: if (hs) nstate = ST_EXEC;
         ST_EXEC: nstate = ST_RESP;
         ST_RESP: if (bus.rsp_ready) nstate = ST_IDLE;
         default: nstate = ST_IDLE;
      endcase
   end

   // ready is offered only in IDLE and never while reset is held
   always_comb begin
      bus.req_ready = '0;
      bus.busy      = (state != ST_IDLE);
      if (state == ST_IDLE && rst_n) bus.req_ready = pick_gnt;
   end

   // latch operands and id at the grant edge, advance the pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         la     <= '0;
         lb     <= '0;
         lid    <= '0;
         rr_ptr <= '0;
      end else if (hs) begin
         la     <= bus.req_a[int'(pick_idx)*W +: W];
         lb     <= bus.req_b[int'(pick_idx)*W +: W];
         lid    <= pick_idx;
         rr_ptr <= IDW'(nxt_ptr(int'(pick_idx), NREQ));
      end
   end

   // register the And16 result and hold it until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_id    <= '0;
      end else if (state == ST_EXEC) begin
         bus.rsp_valid <= 1'b1;
         bus.rsp_data  <= and_y;
         bus.rsp_id    <= lid;
      end else if (state == ST_RESP && bus.rsp_ready) begin
         bus.rsp_valid <= 1'b0;
      end
   end

`ifdef AND16_RR_SCHED_PERF_EN
   // completed responses (wrapping) and blocked cycles (saturating)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_count  <= '0;
         stall_count <= '0;
      end else begin
         if (bus.rsp_valid && bus.rsp_ready)
            perf_count <= perf_count + 1'b1;
         if (|bus.req_valid && bus.req_ready == '0
             && stall_count != {W{1'b1}})
            stall_count <= stall_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_and16_rr_sched.sv
// Directed self-checking bench for and16_rr_sched.
// Optional counters checked when AND16_RR_SCHED_PERF_EN is defined.
module tb_and16_rr_sched;

   logic clk = 1'b0;
   logic rst_n;
   int   ntot  = 0;
   int   nfail = 0;

   and16_rr_sched_if #(.NREQ(4), .IDW(2)) bus ();

`ifdef AND16_RR_SCHED_PERF_EN
   logic [15:0] perf_count;
   logic [15:0] stall_count;
`endif

   and16_rr_sched #(
      .NREQ (4),
      .IDW  (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef AND16_RR_SCHED_PERF_EN
      ,
      .perf_count  (perf_count),
      .stall_count (stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntot++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [15:0] a,
                           input logic [15:0] b);
      bus.req_a[16*i +: 16] = a;
      bus.req_b[16*i +: 16] = b;
   endtask

   // one full transaction with rsp_ready high; lane operands are
   // scrambled after the grant to prove they were latched
   task automatic txn(input int id, input logic [15:0] exp,
                      input bit poke);
      #1;
      chk("grant", bus.req_ready, 32'(1 << id));
      chk("idle_busy", bus.busy, 0);
      step();
      bus.req_valid[id] = 1'b0;
      set_lane(id, 16'hFFFF, 16'hFFFF);
      if (poke) bus.req_valid = 4'b0010;
      #1;
      chk("exec_busy", bus.busy, 1);
      chk("exec_ready", bus.req_ready, 0);
      chk("exec_rsp", bus.rsp_valid, 0);
      step();
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_data", bus.rsp_data, exp);
      chk("rsp_id", bus.rsp_id, id);
      chk("resp_ready", bus.req_ready, 0);
      step();
      if (poke) bus.req_valid = 4'b0000;
      chk("done_valid", bus.rsp_valid, 0);
      chk("done_busy", bus.busy, 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 4'hF;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      #2;
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_data", bus.rsp_data, 0);
      chk("rst_id", bus.rsp_id, 0);
      chk("rst_busy", bus.busy, 0);
`ifdef AND16_RR_SCHED_PERF_EN
      chk("rst_perf", perf_count, 0);
      chk("rst_stall", stall_count, 0);
`endif
      bus.req_valid = 4'h0;
      #10;
      rst_n = 1'b1;

      // all four valid: grants 0,1,2,3
      set_lane(0, 16'h042B, 16'h6D2E);
      set_lane(1, 16'h0A31, 16'hA271);
      set_lane(2, 16'h0B36, 16'hBA75);
      set_lane(3, 16'h141F, 16'hFB59);
      bus.req_valid = 4'hF;
      txn(0, 16'h042A, 1'b0);
      txn(1, 16'h0231, 1'b0);
      txn(2, 16'h0A34, 1'b0);
      txn(3, 16'h1019, 1'b0);

      // single request on requester 0
      set_lane(0, 16'h0371, 16'hCEE0);
      bus.req_valid = 4'b0001;
      txn(0, 16'h0260, 1'b0);

      // backpressure on requester 2 (pointer now 1)
      set_lane(2, 16'hFFFF, 16'h1234);
      bus.req_valid = 4'b0100;
      bus.rsp_ready = 1'b0;
      #1;
      chk("bp_grant", bus.req_ready, 4'b0100);
      step();
      bus.req_valid = 4'b0001;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", bus.rsp_valid, 1);
         chk("bp_data", bus.rsp_data, 16'h1234);
         chk("bp_id", bus.rsp_id, 2);
         chk("bp_ready", bus.req_ready, 0);
         step();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_hold", bus.rsp_valid, 1);
      step();
      bus.req_valid = 4'b0000;
      chk("bp_release", bus.rsp_valid, 0);
      chk("bp_idle", bus.busy, 0);

      // fairness wrap: grant 3, then 1 before 3
      set_lane(3, 16'hAAAA, 16'h0FF0);
      bus.req_valid = 4'b1000;
      txn(3, 16'h0AA0, 1'b0);
      set_lane(1, 16'hF0F0, 16'h3C3C);
      set_lane(3, 16'hAAAA, 16'h0FF0);
      bus.req_valid = 4'b1010;
      txn(1, 16'h3030, 1'b0);
      txn(3, 16'h0AA0, 1'b0);

      // reset while in EXEC drops the transaction
      set_lane(2, 16'h5555, 16'hFFFF);
      bus.req_valid = 4'b0100;
      #1;
      chk("mid_grant", bus.req_ready, 4'b0100);
      step();
      bus.req_valid = 4'b0000;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_busy", bus.busy, 0);
      chk("mid_valid", bus.rsp_valid, 0);
      chk("mid_data", bus.rsp_data, 0);
      chk("mid_id", bus.rsp_id, 0);
      step();
      chk("mid_nopulse", bus.rsp_valid, 0);
      #2;
      rst_n = 1'b1;
      set_lane(2, 16'h5555, 16'h0F0F);
      set_lane(3, 16'h1111, 16'h1111);
      bus.req_valid = 4'b1100;
      txn(2, 16'h0505, 1'b0);
      bus.req_valid = 4'b0000;

`ifdef AND16_RR_SCHED_PERF_EN
      // counters: three responses, two blocked cycles
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      chk("perf_clr", perf_count, 0);
      set_lane(0, 16'h1111, 16'hFFFF);
      bus.req_valid = 4'b0001;
      txn(0, 16'h1111, 1'b0);
      set_lane(0, 16'h2222, 16'hFFFF);
      bus.req_valid = 4'b0001;
      txn(0, 16'h2222, 1'b1);
      set_lane(0, 16'h3333, 16'hFFFF);
      bus.req_valid = 4'b0001;
      txn(0, 16'h3333, 1'b0);
      chk("perf_count", perf_count, 3);
      chk("stall_count", stall_count, 2);
`endif

      $display("%0d/%0d checks passed", ntot - nfail, ntot);
      $finish;
   end

endmodule
